// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - producer/register-file bundle for the write-back queue
//
// Purpose: groups the two producer request paths, the register file write
//          port and the queue status outputs into one bundle.
// Signals:
//   alu_valid/alu_ready/alu_addr/alu_data   ALU result write requests
//   mem_valid/mem_ready/mem_addr/mem_data   memory-load write requests
//   wr_hold                                 suppresses issue for a cycle
//   wr_enable/wr_address/bus_data_in        registered register file write port
//   pending_mask                            per-register queued-or-issuing flags
//   count/full/empty                        FIFO occupancy status
// Modports: slave = queue side, master = producer/consumer side.
interface writeback_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NREG  = 2 ** ADDR_WIDTH;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  wr_hold;
    logic                  wr_enable;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic [DATA_WIDTH-1:0] bus_data_in;
    logic [NREG-1:0]       pending_mask;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  wr_hold,
        output alu_ready, mem_ready,
        output wr_enable, wr_address, bus_data_in,
        output pending_mask, count, full, empty
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output wr_hold,
        input  alu_ready, mem_ready,
        input  wr_enable, wr_address, bus_data_in,
        input  pending_mask, count, full, empty
    );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order register write-back queue for ALU and load producers
//
// Purpose: buffers write-back requests from the load path (fixed priority)
//          and the ALU path in one FIFO and issues one register file write
//          per cycle from a registered output stage. Exports a pending mask
//          of every register with a write queued or issuing.
// Ports:
//   i_clk   clock, rising edge
//   i_clr   asynchronous active-high reset; also forces both readies low
//   bus     writeback_queue_if.slave (requests, write port, status)
module writeback_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic               i_clk,
    input  logic               i_clr,
    writeback_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_enable;
    logic [ADDR_WIDTH-1:0] r_wr_address;
    logic [DATA_WIDTH-1:0] r_bus_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_mem_ready;
    logic                  w_alu_ready;
    logic                  w_push_mem;
    logic                  w_push_alu;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_push_addr;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [NREG-1:0]       w_pending;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Full blocks enqueue outright, even when a pop frees a slot on the same edge.
    assign w_mem_ready = !w_full && !i_clr;
    assign w_alu_ready = !w_full && !bus.mem_valid && !i_clr;

    assign w_push_mem  = bus.mem_valid && w_mem_ready;
    assign w_push_alu  = bus.alu_valid && w_alu_ready;
    assign w_push      = w_push_mem || w_push_alu;
    assign w_push_addr = w_push_mem ? bus.mem_addr : bus.alu_addr;
    assign w_push_data = w_push_mem ? bus.mem_data : bus.alu_data;
    assign w_pop       = !bus.wr_hold && !w_empty;

    // Payload storage needs no reset: r_vld qualifies every entry.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= w_push_addr;
            r_data[r_wr_ptr] <= w_push_data;
        end
    end

    // Push and pop never target the same slot: a push needs a free slot and
    // a pop needs an occupied one, so r_wr_ptr != r_rd_ptr whenever both fire.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: address/data hold their last value when nothing issues.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_wr_enable  <= 1'b0;
            r_wr_address <= '0;
            r_bus_data   <= '0;
        end else if (w_pop) begin
            r_wr_enable  <= 1'b1;
            r_wr_address <= r_addr[r_rd_ptr];
            r_bus_data   <= r_data[r_rd_ptr];
        end else begin
            r_wr_enable  <= 1'b0;
        end
    end

    // A register stays pending while any queued entry targets it and during
    // the cycle its write is presented to the register file.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pending[r_addr[i]] = 1'b1;
            end
        end
        if (r_wr_enable) begin
            w_pending[r_wr_address] = 1'b1;
        end
    end

    assign bus.mem_ready    = w_mem_ready;
    assign bus.alu_ready    = w_alu_ready;
    assign bus.wr_enable    = r_wr_enable;
    assign bus.wr_address   = r_wr_address;
    assign bus.bus_data_in  = r_bus_data;
    assign bus.pending_mask = w_pending;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - randomized and directed bench for writeback_queue against a queue model
module tb_writeback_queue;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;

    writeback_queue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending writes as {addr, data} in arrival order, plus
    // the write currently presented to the register file.
    logic [AW+DW-1:0] q[$];
    logic             m_en;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        foreach (q[i]) m[q[i][AW+DW-1:DW]] = 1'b1;
        if (m_en) m[m_addr] = 1'b1;
        return m;
    endfunction

    // Called at a falling edge: drive one cycle of inputs, check everything
    // against the model, advance the model across the next rising edge.
    task automatic do_cycle(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                            input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                            input logic hold, output logic acc_m, output logic acc_a);
        int sz;
        logic [AW+DW-1:0] e;
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.wr_hold   = hold;
        #1;
        sz = q.size();
        chk("mem_ready",    64'(bus.mem_ready),    64'(sz < DEPTH));
        chk("alu_ready",    64'(bus.alu_ready),    64'(sz < DEPTH && !mv));
        chk("wr_enable",    64'(bus.wr_enable),    64'(m_en));
        chk("wr_address",   64'(bus.wr_address),   64'(m_addr));
        chk("bus_data_in",  64'(bus.bus_data_in),  64'(m_data));
        chk("count",        64'(bus.count),        64'(sz));
        chk("full",         64'(bus.full),         64'(sz == DEPTH));
        chk("empty",        64'(bus.empty),        64'(sz == 0));
        chk("pending_mask", 64'(bus.pending_mask), 64'(model_mask()));
        acc_m = mv && sz < DEPTH;
        acc_a = av && !mv && sz < DEPTH;
        if (!hold && sz > 0) begin
            e = q.pop_front();
            m_en = 1'b1; m_addr = e[AW+DW-1:DW]; m_data = e[DW-1:0];
        end else begin
            m_en = 1'b0;
        end
        if (acc_m) q.push_back({ma, md});
        else if (acc_a) q.push_back({aa, ad});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic am, aa;
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, am, aa);
    endtask

    task automatic alu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic hold);
        logic am, aa;
        do_cycle(0, 0, 0, 1, a, d, hold, am, aa);
    endtask

    // Asserted mid-cycle with both producers requesting: reset is asynchronous.
    task automatic do_reset();
        bus.mem_valid = 1'b1; bus.alu_valid = 1'b1; bus.wr_hold = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("rst_wr_enable", 64'(bus.wr_enable),    64'd0);
        chk("rst_count",     64'(bus.count),        64'd0);
        chk("rst_empty",     64'(bus.empty),        64'd1);
        chk("rst_pending",   64'(bus.pending_mask), 64'd0);
        chk("rst_mem_ready", 64'(bus.mem_ready),    64'd0);
        chk("rst_alu_ready", 64'(bus.alu_ready),    64'd0);
        chk("rst_address",   64'(bus.wr_address),   64'd0);
        chk("rst_data",      64'(bus.bus_data_in),  64'd0);
        q.delete();
        m_en = 1'b0; m_addr = '0; m_data = '0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
    endtask

    initial begin
        logic am, aa;
        int idx, cyc;
        bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.wr_hold = 0;
        m_en = 1'b0; m_addr = '0; m_data = '0;
        @(negedge clk);
        do_reset();
        idle(2);

        // Single ALU write R1=18
        alu_wr(4'd1, 32'd18, 1'b0);
        idle(4);

        // Load beats ALU on collision; ALU retries next cycle
        do_cycle(1, 4'd3, 32'd69, 1, 4'd0, 32'd26, 0, am, aa);
        chk("collision_mem_first", 64'({am, aa}), 64'b10);
        do_cycle(0, 0, 0, 1, 4'd0, 32'd26, 0, am, aa);
        chk("collision_alu_next", 64'(aa), 64'd1);
        idle(4);

        // Fill under hold, one blocked attempt, then drain
        for (int i = 0; i < 4; i++) alu_wr(AW'(4 + i), DW'(1 + i), 1'b1);
        do_cycle(0, 0, 0, 1, 4'd9, 32'd99, 1, am, aa);
        chk("full_blocks_alu", 64'(aa), 64'd0);
        idle(6);

        // Same register twice
        alu_wr(4'd2, 32'd5, 1'b0);
        alu_wr(4'd2, 32'd9, 1'b0);
        idle(4);

        // Ten writes with hold toggling every 3 cycles
        idx = 0; cyc = 0;
        while (idx < 10 && cyc < 200) begin
            do_cycle(0, 0, 0, 1, AW'(idx), DW'(32'h100 + idx), 1'(((cyc / 3) % 2)), am, aa);
            if (aa) idx++;
            cyc++;
        end
        chk("wrap_all_accepted", 64'(idx), 64'd10);
        idle(8);

        // Reset with a full queue: nothing may issue afterwards
        for (int i = 0; i < 4; i++) alu_wr(AW'(10 + i), DW'(500 + i), 1'b1);
        do_reset();
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom_range(0, 2) == 0), AW'($urandom), $urandom,
                     ($urandom_range(0, 1) == 0), AW'($urandom), $urandom,
                     ($urandom_range(0, 2) == 0), am, aa);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
